// File: rtl/axi_cfg_regfile.sv
// AXI4-Lite configuration register file: read/write control words, read-only status words.
// Define AXI_CFG_IRQ_EN to add the IRQ_STATUS / IRQ_ENABLE words and the irq output.
module axi_cfg_regfile #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int C_NUM_CTRL_REGS    = 8,
    parameter int C_NUM_STAT_REGS    = 8
) (
    input  logic                                          S_AXI_ACLK,
    input  logic                                          S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
    input  logic                                          S_AXI_AWVALID,
    output logic                                          S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
    input  logic                                          S_AXI_WVALID,
    output logic                                          S_AXI_WREADY,
    output logic [1:0]                                    S_AXI_BRESP,
    output logic                                          S_AXI_BVALID,
    input  logic                                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
    input  logic                                          S_AXI_ARVALID,
    output logic                                          S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
    output logic [1:0]                                    S_AXI_RRESP,
    output logic                                          S_AXI_RVALID,
    input  logic                                          S_AXI_RREADY,
    output logic [C_NUM_CTRL_REGS*C_S_AXI_DATA_WIDTH-1:0] ctrl_regs,
    output logic [C_NUM_CTRL_REGS-1:0]                    ctrl_wr_stb,
    input  logic [C_NUM_STAT_REGS*C_S_AXI_DATA_WIDTH-1:0] stat_regs,
    input  logic [C_NUM_STAT_REGS-1:0]                    irq_src,
    output logic                                          irq
);

    localparam int          DW = C_S_AXI_DATA_WIDTH;
    localparam int          AW = C_S_AXI_ADDR_WIDTH;
    localparam int          NB = DW / 8;
    localparam int unsigned NC = C_NUM_CTRL_REGS;
    localparam int unsigned NS = C_NUM_STAT_REGS;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic          ready_en;
    logic          aw_full;
    logic [AW-3:0] aw_addr_q;
    logic          w_full;
    logic [DW-1:0] w_data_q;
    logic [NB-1:0] w_strb_q;
    logic          bvalid;
    logic [1:0]    bresp;
    logic          rvalid;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;
    logic          commit;
    logic          wr_in_map;
    logic [31:0]   aw_idx;
    logic [31:0]   ar_idx;
    logic [DW-1:0] wmask;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic [NC:0][DW-1:0] ctrl_acc;
    logic [NS:0][DW-1:0] stat_acc;
    logic          unused_inputs;

    assign aw_idx = 32'(aw_addr_q);
    assign ar_idx = 32'(S_AXI_ARADDR[AW-1:2]);
    assign commit = aw_full && w_full && !bvalid;

    // ready_en keeps every READY low through reset and raises them on the first edge after release
    assign S_AXI_AWREADY = ready_en && !aw_full && !bvalid;
    assign S_AXI_WREADY  = ready_en && !w_full && !bvalid;
    assign S_AXI_ARREADY = ready_en && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    for (genvar b = 0; b < NB; b++) begin : g_wmask
        assign wmask[b*8 +: 8] = {8{w_strb_q[b]}};
    end

`ifdef AXI_CFG_IRQ_EN
    localparam int unsigned IRQ_STAT_IDX = NC + NS;
    localparam int unsigned IRQ_EN_IDX   = NC + NS + 1;
    localparam int unsigned MAP_END      = NC + NS + 2;

    logic [NS-1:0] irq_src_q;
    logic [NS-1:0] irq_status;
    logic [NS-1:0] irq_enable;
    logic [NS-1:0] irq_wr_bits;
    logic [NS-1:0] irq_clr;
    logic          irq_q;

    assign irq_wr_bits = w_data_q[NS-1:0] & wmask[NS-1:0];
    assign irq_clr     = (commit && aw_idx == IRQ_STAT_IDX) ? irq_wr_bits : '0;
    assign irq         = irq_q;

    // A new source edge is OR-ed in after the clear so it survives a coincident write-1
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_src_q  <= '0;
            irq_status <= '0;
            irq_enable <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_src_q  <= irq_src;
            irq_status <= (irq_status & ~irq_clr) | (irq_src & ~irq_src_q);
            if (commit && aw_idx == IRQ_EN_IDX)
                irq_enable <= (irq_enable & ~wmask[NS-1:0]) | irq_wr_bits;
            irq_q <= |(irq_status & irq_enable);
        end
    end

    assign unused_inputs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    localparam int unsigned MAP_END = NC + NS;

    assign irq           = 1'b0;
    assign unused_inputs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], irq_src};
`endif

    assign wr_in_map = aw_idx < MAP_END;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en  <= 1'b0;
            aw_full   <= 1'b0;
            aw_addr_q <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_full   <= 1'b1;
                aw_addr_q <= S_AXI_AWADDR[AW-1:2];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_full   <= 1'b1;
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_in_map ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid  <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
        end
    end

    // Per-register storage; the read mux is an OR chain of index-qualified words
    assign ctrl_acc[0] = '0;
    for (genvar g = 0; g < NC; g++) begin : g_ctrl
        logic [DW-1:0] q;
        logic          stb_q;
        logic          hit;

        assign hit = commit && (aw_idx == 32'(g));

        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                q     <= '0;
                stb_q <= 1'b0;
            end else begin
                stb_q <= hit;
                if (hit)
                    q <= (q & ~wmask) | (w_data_q & wmask);
            end
        end

        assign ctrl_regs[g*DW +: DW] = q;
        assign ctrl_wr_stb[g]        = stb_q;
        assign ctrl_acc[g+1]         = ctrl_acc[g] | ({DW{ar_idx == 32'(g)}} & q);
    end

    assign stat_acc[0] = '0;
    for (genvar g = 0; g < NS; g++) begin : g_stat
        assign stat_acc[g+1] = stat_acc[g] |
                               ({DW{ar_idx == NC + 32'(g)}} & stat_regs[g*DW +: DW]);
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (ar_idx < NC) begin
            rd_data = ctrl_acc[NC];
            rd_resp = RESP_OKAY;
        end else if (ar_idx < NC + NS) begin
            rd_data = stat_acc[NS];
            rd_resp = RESP_OKAY;
        end
`ifdef AXI_CFG_IRQ_EN
        else if (ar_idx == IRQ_STAT_IDX) begin
            rd_data[NS-1:0] = irq_status;
            rd_resp         = RESP_OKAY;
        end else if (ar_idx == IRQ_EN_IDX) begin
            rd_data[NS-1:0] = irq_enable;
            rd_resp         = RESP_OKAY;
        end
`endif
    end

    // Read data is captured from pre-commit register values, so a coincident write is not visible
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid  <= 1'b0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                rvalid  <= 1'b1;
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end else if (rvalid && S_AXI_RREADY) begin
                rvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi_cfg_regfile.md
AXI_CFG_REGFILE -- requirements
Module: axi_cfg_regfile

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, 32, bus and register width (32 only).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, 9, byte-address width.
REQ-003 SHALL have parameter C_NUM_CTRL_REGS, 8, number of read/write control registers (1..32).
REQ-004 SHALL have parameter C_NUM_STAT_REGS, 8, number of read-only status registers (1..32).
REQ-005 SHALL have port S_AXI_ACLK  in  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports S_AXI_AWADDR in ADDR_W, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1: write-address channel.
REQ-008 SHALL have ports S_AXI_WDATA in DATA_W, S_AXI_WSTRB in DATA_W/8, S_AXI_WVALID in 1, S_AXI_WREADY out 1: write-data channel.
REQ-009 SHALL have ports S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1: write response.
REQ-010 SHALL have ports S_AXI_ARADDR in ADDR_W, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1: read address.
REQ-011 SHALL have ports S_AXI_RDATA out DATA_W, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1: read data.
REQ-012 SHALL have port ctrl_regs  out  NC*DATA_W  flattened control registers, reg i at bits [i*32+:32].
REQ-013 SHALL have port ctrl_wr_stb  out  NC  one-cycle pulse per control register on commit.
REQ-014 SHALL have port stat_regs  in  NS*DATA_W  flattened status inputs, sampled on read.
REQ-015 SHALL have ports irq_src  in  NS  event sources, and irq  out  1  interrupt request.

Function
REQ-016 SHALL decode word index = AWADDR/ARADDR[ADDR_W-1:2]; low two bits ignored.
REQ-017 SHALL map words 0..NC-1 to control, NC..NC+NS-1 to status, NC+NS to IRQ_STATUS, NC+NS+1 to IRQ_ENABLE.
REQ-018 SHALL capture AW and W beats independently into holding registers; AWREADY/WREADY high only while their holding register is empty and BVALID low.
REQ-019 SHALL commit a write the cycle after both beats are held, asserting BVALID and the matching ctrl_wr_stb bit on that same registered edge.
REQ-020 SHALL update only bytes whose WSTRB bit is set; WSTRB=0 commits nothing but still pulses ctrl_wr_stb and returns OKAY.
REQ-021 SHALL hold BVALID/BRESP until BREADY; holding registers free on B handshake.
REQ-022 SHALL drive ARREADY = ~RVALID; on AR handshake register RDATA/RRESP and assert RVALID next cycle, held until RREADY.
REQ-023 SHALL return RESP OKAY (00) in range, SLVERR (10) and RDATA=0 for index beyond the map, with no state change.
REQ-024 SHALL ignore writes to status words with OKAY response.
REQ-025 SHALL, on same-cycle read and commit to one register, return the pre-write value.
REQ-026 SHALL allow a read and a write to proceed concurrently with no mutual stall.

Reset
REQ-027 SHALL on ARESETN low immediately clear ctrl_regs, holding registers, IRQ state, ctrl_wr_stb, BVALID, RVALID, RDATA, BRESP, RRESP, irq, and drive AWREADY, WREADY, ARREADY low.
REQ-028 SHALL drive AWREADY, WREADY, ARREADY high on the first clock edge after reset release.
REQ-029 SHALL abandon in-flight transactions on reset with no partial register update.

Configuration
REQ-030 SHALL compile interrupt logic only when AXI_CFG_IRQ_EN is defined.
REQ-031 With AXI_CFG_IRQ_EN: IRQ_STATUS bit i SHALL set on a registered rising edge of irq_src[i], clear on write-1 (set wins over simultaneous clear); irq SHALL be registered |(IRQ_STATUS & IRQ_ENABLE).
REQ-032 Without AXI_CFG_IRQ_EN: IRQ words SHALL decode as out of range (SLVERR), irq tied 0, irq_src unused.

Verification
REQ-033 Write 0xDEADBEEF to word 2, WSTRB=0xF, W beat 3 cycles before AW -> BRESP=00, ctrl_regs[95:64]=0xDEADBEEF, ctrl_wr_stb=0x04 for one cycle.
REQ-034 Word 0 = 0x11223344, write 0xAABBCCDD WSTRB=0x5 -> readback 0x11BB33DD.
REQ-035 stat_regs word 1 = 0x0000CAFE, read byte addr 0x24 (NC=8) -> RDATA=0x0000CAFE, RRESP=00; RREADY held low 4 cycles -> RVALID/RDATA stable, ARREADY low.
REQ-036 Read addr 0x1FC and write 0x1FC -> SLVERR, RDATA=0, no ctrl_regs change.
REQ-037 IRQ_EN build: IRQ_ENABLE=0x1, pulse irq_src[0] -> irq=1 within 3 cycles; W1C 0x1 coincident with new edge -> bit stays 1.
REQ-038 Assert ARESETN low mid-write with BVALID pending -> BVALID, ctrl_regs=0 asynchronously; first post-reset write completes normally.
